s_mem_rr_arbiter: RTL and testbench
===================================

Name: s_mem_rr_arbiter

Overview:
- Round-robin arbiter and access sequencer for the shared single-port S-memory in the RC4 datapath.
- Lets NUM_REQ state machines (init, key-schedule swap, decrypt PRGA, checker) issue read/write accesses through one memory port.
- Each access uses a level-request / one-cycle-ack handshake; read latency is configurable.
- Read data is returned registered with the requester's ack.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
RD_LAT, 2, cycles from address driven to mem_q valid (1..7)

Ports:
sm_clk  in  1  clock
reset  in  1  synchronous active-high reset
req  in  NUM_REQ  level request per requester, held until its ack
req_wren  in  NUM_REQ  1 = write, 0 = read, per requester
req_addr  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed, requester i at [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
rdata  out  DATA_W  read data; valid in ack cycle, held until next read capture
grant_id  out  $clog2(NUM_REQ)  index of current or last winner
busy  out  1  high when state != IDLE
mem_addr  out  ADDR_W  to memory
mem_wdata  out  DATA_W  to memory
mem_wren  out  1  to memory
mem_q  in  DATA_W  from memory

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is sm_clk.
- Reset values: state IDLE; ack 0; rdata 0; grant_id 0; busy 0; mem_addr, mem_wdata, mem_wren 0; last_grant NUM_REQ-1, so requester 0 wins first.
- States: IDLE, ISSUE, WAIT, CAPTURE, ACK.
- IDLE:
  - If any req bit is set, winner = first set bit searching from (last_grant+1) mod NUM_REQ upward, wrapping.
  - In the same edge, register grant_id, mem_addr, mem_wdata, and the winner's wren; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (cycle t):
  - mem_wren = winner's wren for this cycle only.
  - Write: go to ACK.
  - Read: go to WAIT if RD_LAT>1, else go to CAPTURE.
- WAIT: occupies cycles t+1 .. t+RD_LAT-1; mem_addr held; down-counter of width 3.
- CAPTURE (cycle t+RD_LAT): rdata <= mem_q at the closing edge.
- ACK:
  - ack[grant_id]=1 for exactly one cycle; last_grant <= grant_id; return to IDLE.
  - Write completes at t+1; read completes at t+RD_LAT+1.
- Latency from req seen in IDLE to ack: write 2 cycles; read RD_LAT+2 cycles.
- Request fields are sampled only at the grant edge; later changes are ignored until the next grant.
- req still high in the cycle after ack counts as a new request; requesters drop req on seeing ack.
- req withdrawn mid-access: the access still completes and ack still pulses.
- mem_wren is 0 in every state except ISSUE-with-write; mem_addr and mem_wdata hold their last values.
- rdata is not updated by writes.
- Reset mid-access: access is aborted, no ack is generated, all outputs return to reset values at the next edge.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 accesses.

Optional Feature:
- Macro: S_MEM_ARB_PRIO0_EN.
- Defined: requester 0 is strict highest priority. In IDLE, req[0] wins regardless of last_grant; the others round-robin among themselves, and last_grant is not updated when requester 0 wins.
- Undefined: pure round-robin as described above.

Test Plan:
- After reset, req=4'b0001, read addr 0x10, mem model returns 0x5A with RD_LAT=2 -> ack=4'b0001 exactly 4 cycles after req seen; rdata=0x5A; mem_wren never high.
- req[2] write addr 0x33 data 0xC7 -> exactly one ISSUE cycle with mem_wren=1, mem_addr=0x33, mem_wdata=0xC7; ack=4'b0100 on the next cycle.
- All four req held high, 8 accesses -> grant order 0,1,2,3,0,1,2,3; one ack per access; busy stays high between accesses except one IDLE cycle.
- Assert reset during WAIT of a read from requester 1 -> no ack; all outputs 0 next cycle; first grant after reset goes to requester 0.
- req[3] read, then req[3] changes addr and drops req during WAIT -> read uses the original addr; ack[3] still pulses once.
- S_MEM_ARB_PRIO0_EN defined, req=4'b1111 continuously -> requester 0 wins every arbitration; undefined -> rotation 0,1,2,3.

Source files
------------

// File: rtl/s_mem_rr_arbiter_if.sv
// Requester and memory-port bundle for the shared S-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters and memory model.
interface s_mem_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_wren;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [GID_W-1:0]          grant_id;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_wren;
    logic [DATA_W-1:0]         mem_q;

    modport slave (
        input  req, req_wren, req_addr, req_wdata, mem_q,
        output ack, rdata, grant_id, busy, mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output req, req_wren, req_addr, req_wdata, mem_q,
        input  ack, rdata, grant_id, busy, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/s_mem_rr_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port RC4 S-memory.
// Optional macro S_MEM_ARB_PRIO0_EN makes requester 0 strict highest priority.
module s_mem_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 2
) (
    input  logic               sm_clk,
    input  logic               reset,
    s_mem_rr_arbiter_if.slave  bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // WAIT spans RD_LAT-1 cycles; the counter runs down to zero.
    localparam logic [2:0] WAIT_LOAD = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        ACK
    } state_t;

    state_t             state;
    logic [GID_W-1:0]   last_grant;
    logic [2:0]         wait_cnt;
    logic [GID_W-1:0]   winner;

    // First set bit searching upward from last+1, wrapping.
    function automatic logic [GID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [GID_W-1:0]   last);
        logic [GID_W-1:0] pick;
        logic [GID_W-1:0] cand;
        int               idx;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = GID_W'(idx);
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

`ifdef S_MEM_ARB_PRIO0_EN
    logic [NUM_REQ-1:0] req_others;

    always_comb begin
        req_others    = bus.req;
        req_others[0] = 1'b0;
        winner        = bus.req[0] ? '0 : rr_pick(req_others, last_grant);
    end
`else
    always_comb begin
        winner = rr_pick(bus.req, last_grant);
    end
`endif

    always_ff @(posedge sm_clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= GID_W'(NUM_REQ - 1);
            wait_cnt      <= '0;
            bus.ack       <= '0;
            bus.rdata     <= '0;
            bus.grant_id  <= '0;
            bus.busy      <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wren  <= 1'b0;
        end else begin
            case (state)
                // Grant edge: request fields are captured here and nowhere else.
                IDLE: begin
                    if (|bus.req) begin
                        bus.grant_id  <= winner;
                        bus.mem_addr  <= bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
                        bus.mem_wdata <= bus.req_wdata[int'(winner)*DATA_W +: DATA_W];
                        bus.mem_wren  <= bus.req_wren[winner];
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                // Address on the port; the write strobe lives only in this cycle.
                ISSUE: begin
                    bus.mem_wren <= 1'b0;
                    if (bus.mem_wren) begin
                        bus.ack <= onehot(bus.grant_id);
                        state   <= ACK;
                    end else if (RD_LAT > 1) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                // mem_q is valid this cycle; it is presented with the ack.
                CAPTURE: begin
                    bus.rdata <= bus.mem_q;
                    bus.ack   <= onehot(bus.grant_id);
                    state     <= ACK;
                end
                ACK: begin
                    bus.ack  <= '0;
                    bus.busy <= 1'b0;
`ifdef S_MEM_ARB_PRIO0_EN
                    // Requester 0 sits outside the rotation, so it never moves the pointer.
                    if (bus.grant_id != '0) begin
                        last_grant <= bus.grant_id;
                    end
`else
                    last_grant <= bus.grant_id;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_s_mem_rr_arbiter.sv
// Directed bench for s_mem_rr_arbiter: memory model with read pipeline and an ack scoreboard.
module tb_s_mem_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int RD_LAT  = 2;

    logic sm_clk = 1'b0;
    logic reset;

    always #5 sm_clk = ~sm_clk;

    s_mem_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    s_mem_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .sm_clk(sm_clk),
        .reset (reset),
        .bus   (bus)
    );

    // Unwritten locations read back as addr ^ 0x4A.
    logic [7:0]   mem [256];
    logic [255:0] written;
    logic [7:0]   pipe [RD_LAT];

    always @(posedge sm_clk) begin
        if (reset) begin
            written <= '0;
        end else if (bus.mem_wren) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
        pipe[0] <= written[bus.mem_addr] ? mem[bus.mem_addr] : (bus.mem_addr ^ 8'h4A);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign bus.mem_q = pipe[RD_LAT-1];

    typedef struct packed {
        logic [1:0] id;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int ack_count = 0;
    int ack_cyc   = 0;
    int wr_cnt    = 0;
    int idle_cnt  = 0;
    int t0        = 0;
    int base      = 0;
    bit auto_drop = 1'b1;
    bit count_idle = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    function automatic exp_t mk(input int id, input bit rd, input logic [7:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.rd   = rd;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic [3:0] exp_vec;
        @(negedge sm_clk);
        cyc++;
        if (bus.mem_wren === 1'b1) begin
            wr_cnt++;
            wr_addr = bus.mem_addr;
            wr_data = bus.mem_wdata;
        end
        if (count_idle && bus.busy === 1'b0) idle_cnt++;
        if (bus.ack !== 4'b0000) begin
            ack_count++;
            ack_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                e       = sb.pop_front();
                exp_vec = 4'b0001 << e.id;
                chk("ack_vec", 32'(bus.ack), 32'(exp_vec));
                chk("ack_grant_id", 32'(bus.grant_id), 32'(e.id));
                if (e.rd) chk("ack_rdata", 32'(bus.rdata), 32'(e.data));
            end
            if (auto_drop) bus.req = bus.req & ~bus.ack;
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        int b;
        b = budget;
        while (ack_count < target && b > 0) begin
            tick();
            b--;
        end
        chk("ack_count", 32'(ack_count), 32'(target));
    endtask

    initial begin
        bus.req       = '0;
        bus.req_wren  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_mem_wren", 32'(bus.mem_wren), 32'd0);

        // Read by requester 0 from 0x10.
        wr_cnt = 0;
        bus.req_addr[0 +: 8] = 8'h10;
        bus.req_wren[0]      = 1'b0;
        sb.push_back(mk(0, 1'b1, 8'h5A));
        t0 = cyc;
        bus.req[0] = 1'b1;
        wait_acks(1, 20);
        chk("rd_latency", 32'(ack_cyc - t0), 32'(RD_LAT + 2));
        chk("rd_no_wren", 32'(wr_cnt), 32'd0);

        // Write by requester 2.
        tick();
        wr_cnt = 0;
        bus.req_addr[16 +: 8]  = 8'h33;
        bus.req_wdata[16 +: 8] = 8'hC7;
        bus.req_wren[2]        = 1'b1;
        sb.push_back(mk(2, 1'b0, 8'h00));
        t0 = cyc;
        bus.req[2] = 1'b1;
        wait_acks(2, 20);
        chk("wr_latency", 32'(ack_cyc - t0), 32'd2);
        chk("wr_strobe_count", 32'(wr_cnt), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'h33);
        chk("wr_data", 32'(wr_data), 32'hC7);
        chk("rdata_kept_on_write", 32'(bus.rdata), 32'h5A);

        // Requester 1 reads the written location back.
        tick();
        bus.req_addr[8 +: 8] = 8'h33;
        bus.req_wren[1]      = 1'b0;
        sb.push_back(mk(1, 1'b1, 8'hC7));
        bus.req[1] = 1'b1;
        wait_acks(3, 20);
        tick();

        // Reset during WAIT of a read by requester 1.
        bus.req_addr[8 +: 8] = 8'h20;
        bus.req[1] = 1'b1;
        tick();
        tick();
        chk("abort_busy_in_wait", 32'(bus.busy), 32'd1);
        chk("abort_addr_in_wait", 32'(bus.mem_addr), 32'h20);
        reset   = 1'b1;
        bus.req = '0;
        tick();
        chk("abort_ack", 32'(bus.ack), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_grant_id", 32'(bus.grant_id), 32'd0);
        chk("abort_rdata", 32'(bus.rdata), 32'd0);
        chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("abort_mem_wren", 32'(bus.mem_wren), 32'd0);
        reset = 1'b0;
        repeat (4) tick();
        chk("abort_no_ack", 32'(ack_count), 32'd3);

        // All four requesters writing continuously.
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_addr[i*8 +: 8]  = 8'(8'h80 + i);
            bus.req_wdata[i*8 +: 8] = 8'(8'hA0 + i);
        end
        bus.req_wren = 4'hF;
        for (int k = 0; k < 8; k++) begin
`ifdef S_MEM_ARB_PRIO0_EN
            sb.push_back(mk(0, 1'b0, 8'h00));
`else
            sb.push_back(mk(k % NUM_REQ, 1'b0, 8'h00));
`endif
        end
        base      = ack_count;
        wr_cnt    = 0;
        auto_drop = 1'b0;
        bus.req   = 4'hF;
        wait_acks(base + 1, 20);
        idle_cnt   = 0;
        count_idle = 1'b1;
        wait_acks(base + 8, 80);
        count_idle = 1'b0;
        bus.req    = '0;
        auto_drop  = 1'b1;
        chk("burst_idle_cycles", 32'(idle_cnt), 32'd7);
        repeat (4) tick();
        chk("burst_no_extra_ack", 32'(ack_count), 32'(base + 8));
        chk("burst_write_count", 32'(wr_cnt), 32'd8);

        // Requester 3 read; addr changes and req drops while the access is in flight.
        bus.req_addr[24 +: 8] = 8'h44;
        bus.req_wren[3]       = 1'b0;
        sb.push_back(mk(3, 1'b1, 8'h0E));
        base = ack_count;
        t0   = cyc;
        bus.req[3] = 1'b1;
        tick();
        bus.req_addr[24 +: 8] = 8'h55;
        tick();
        chk("held_addr_in_wait", 32'(bus.mem_addr), 32'h44);
        bus.req[3] = 1'b0;
        wait_acks(base + 1, 20);
        chk("withdrawn_latency", 32'(ack_cyc - t0), 32'(RD_LAT + 2));
        repeat (4) tick();
        chk("withdrawn_single_ack", 32'(ack_count), 32'(base + 1));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
